// File: rtl/sa_ctrl_pkg.sv
// Shared types and phase-length helpers for the systolic-array pass sequencer.
package sa_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    FEED,
    DRAIN,
    READ,
    DONE
  } sa_state_t;

  // Skewed operands need 2*DIM-1 cycles to sweep the whole array.
  function automatic int feed_len(input int dim);
    return 2 * dim - 1;
  endfunction

  function automatic int drain_len(input int dim);
    return dim - 1;
  endfunction

endpackage

// File: rtl/sa_phase_cnt.sv
// Loadable up-counter with a terminal-count flag; load has priority over increment.
module sa_phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/sa_mem_seq_ctrl.sv
// Sequences one systolic matmul pass: clear, load DIM rows, feed, drain, read DIM rows of C.
// Outputs are decoded from registered state; only the LOAD write strobes follow load_valid directly.
module sa_mem_seq_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic                   load_valid,
  output logic                   load_ready,
  output logic                   memA_en,
  output logic                   memA_WrEn,
  output logic [$clog2(DIM)-1:0] memA_Arow,
  output logic                   memB_en,
  output logic                   sa_en,
  output logic                   sa_clear,
  output logic [$clog2(DIM)-1:0] sa_Crow,
  output logic                   c_valid,
  input  logic                   c_ready
);

  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(2 * DIM);
  localparam logic [RW-1:0] LAST_ROW = RW'(DIM - 1);
  localparam logic [CW-1:0] FEED_TC  = CW'(feed_len(DIM) - 1);
  localparam logic [CW-1:0] DRAIN_TC = CW'(drain_len(DIM) - 1);

  generate
    if (DIM < 2 || BITS_AB < 1 || BITS_C < 1) begin : g_param_check
      $error("sa_mem_seq_ctrl: DIM must be >= 2 and operand widths >= 1");
    end
  endgenerate

  sa_state_t     state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic          cyc_load, cyc_inc, cyc_tc;
  logic [CW-1:0] cyc_tc_val;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = LOAD;
      LOAD:    if (load_valid && row_q == LAST_ROW) state_d = FEED;
      FEED:    if (cyc_tc) state_d = DRAIN;
      DRAIN:   if (cyc_tc) state_d = READ;
      READ:    if (c_ready && row_q == LAST_ROW) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Both counters restart from zero whenever a new state is entered.
  always_comb begin
    row_d = row_q;
    if (state_d != state_q) begin
      row_d = '0;
    end else if ((state_q == LOAD && load_valid) || (state_q == READ && c_ready)) begin
      row_d = row_q + RW'(1);
    end
  end

  assign cyc_load   = (state_d != state_q);
  assign cyc_inc    = (state_q == FEED) || (state_q == DRAIN);
  assign cyc_tc_val = (state_q == DRAIN) ? DRAIN_TC : FEED_TC;

  sa_phase_cnt #(
    .W(CW)
  ) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cyc_load),
    .inc   (cyc_inc),
    .tc_val(cyc_tc_val),
    .tc    (cyc_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    done       = 1'b0;
    load_ready = 1'b0;
    memA_en    = 1'b0;
    memA_WrEn  = 1'b0;
    memA_Arow  = '0;
    memB_en    = 1'b0;
    sa_en      = 1'b0;
    sa_clear   = 1'b0;
    sa_Crow    = '0;
    c_valid    = 1'b0;
    unique case (state_q)
      CLEAR: sa_clear = 1'b1;
      LOAD: begin
        load_ready = 1'b1;
        memA_Arow  = row_q;
        memA_WrEn  = load_valid;
        memB_en    = load_valid;
      end
      FEED, DRAIN: begin
        memA_en = 1'b1;
        memB_en = 1'b1;
        sa_en   = 1'b1;
      end
      READ: begin
        c_valid = 1'b1;
        sa_Crow = row_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
